instr_sequencer: RTL and testbench

Upstream feeder for `computeUnit_0`. It buffers a short program of instruction/operand byte pairs written by the host, then replays them in order to the compute unit over a valid/ready handshake. Its outputs drive the compute unit's `ui_in` (instruction) and `uio_in` (operand). Replay can be started, aborted and, optionally, looped, so the compute unit can be exercised without per-cycle host driving.

---
 rtl/instr_sequencer.sv | 119 +++++++++++
 tb/tb_instr_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers host instruction/operand pairs and replays them over valid/ready.
// Optional replay looping is enabled by defining SEQ_LOOP_EN.
module instr_sequencer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             host_wr,
  input  logic [7:0]       host_instr,
  input  logic [7:0]       host_opnd,
  input  logic             host_start,
  input  logic             host_abort,
  input  logic             host_clear,
  input  logic             host_loop,
  output logic [7:0]       cu_instr,
  output logic [7:0]       cu_opnd,
  output logic             cu_valid,
  input  logic             cu_ready,
  output logic             busy,
  output logic             done,
  output logic [PTR_W:0]   count,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [7:0]       instr_mem [DEPTH];
  logic [7:0]       opnd_mem  [DEPTH];
  logic [PTR_W-1:0] rp_q;
  logic [PTR_W:0]   count_q;
  logic [7:0]       instr_q, opnd_q;
  logic             valid_q, busy_q, done_q, err_q;
  logic             loop, full, last, wr_ok;
  logic [PTR_W-1:0] rp_d;
`ifdef SEQ_LOOP_EN
  assign loop = host_loop;
`else
  logic unused_loop;
  assign unused_loop = host_loop;
  assign loop = 1'b0;
`endif
  assign full  = count_q == (PTR_W+1)'(DEPTH);
  assign last  = {1'b0, rp_q} == count_q - (PTR_W+1)'(1);
  assign rp_d  = (last && loop) ? '0 : rp_q + PTR_W'(1);
  assign wr_ok = ena && state_q == IDLE && host_wr && !host_clear && !host_start && !full;
  always_ff @(posedge clk)
    if (wr_ok) begin
      instr_mem[count_q[PTR_W-1:0]] <= host_instr;
      opnd_mem[count_q[PTR_W-1:0]]  <= host_opnd;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rp_q    <= '0;
      count_q <= '0;
      instr_q <= '0;
      opnd_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (host_clear) begin
            count_q <= '0;
            err_q   <= 1'b0;
          end else if (wr_ok) count_q <= count_q + (PTR_W+1)'(1);
          else if (host_wr) err_q <= 1'b1;
          // a same-cycle clear leaves nothing to replay
          if (host_start) begin
            rp_q <= '0;
            if (count_q == '0 || host_clear) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              instr_q <= instr_mem[0];
              opnd_q  <= opnd_mem[0];
            end
          end
        end
        RUN: begin
          if (host_wr) err_q <= 1'b1;
          if (host_abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cu_ready) begin
            if (last && !loop) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rp_q    <= rp_d;
              instr_q <= instr_mem[rp_d];
              opnd_q  <= opnd_mem[rp_d];
            end
          end
        end
        default: begin
          if (host_wr) err_q <= 1'b1;
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  assign cu_instr = instr_q;
  assign cu_opnd  = opnd_q;
  assign cu_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign err      = err_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer replay, backpressure, abort and errors.
module tb_instr_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic       host_wr = 1'b0, host_start = 1'b0, host_abort = 1'b0, host_clear = 1'b0, host_loop = 1'b0;
  logic [7:0] host_instr = '0, host_opnd = '0;
  logic [7:0] cu_instr, cu_opnd;
  logic       cu_valid, cu_ready = 1'b1, busy, done, err;
  logic [3:0] count;
  int         errs = 0, checks = 0, cyc = 0, st = 0, done_cnt = 0, done_at = 0, d0;
  logic [15:0] exp_q[$];
  logic [15:0] prog[$];

  instr_sequencer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .host_wr(host_wr), .host_instr(host_instr),
    .host_opnd(host_opnd), .host_start(host_start), .host_abort(host_abort),
    .host_clear(host_clear), .host_loop(host_loop), .cu_instr(cu_instr), .cu_opnd(cu_opnd),
    .cu_valid(cu_valid), .cu_ready(cu_ready), .busy(busy), .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (done && ena) begin
      done_cnt++;
      done_at = cyc;
    end
    if (cu_valid) begin
      if (exp_q.size() == 0) chk("extra_valid", 1, 0);
      else if (ena && cu_ready) chk("xfer", {cu_instr, cu_opnd}, exp_q.pop_front());
      else chk("hold", {cu_instr, cu_opnd}, exp_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] i, input logic [7:0] o);
    host_wr = 1'b1; host_instr = i; host_opnd = o;
    tick();
    host_wr = 1'b0;
    if (prog.size() < 8) prog.push_back({i, o});
  endtask

  task automatic clr();
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    prog.delete();
  endtask

  task automatic start();
    foreach (prog[i]) exp_q.push_back(prog[i]);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    st = cyc;
  endtask

  task automatic wait_done(input int lat);
    int d = done_cnt;
    for (int i = 0; i < 60 && done_cnt == d; i++) tick();
    if (done_cnt == d) chk("done_timeout", 0, 1);
    else chk("done_lat", done_at - st, lat);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic load3();
    wr(8'h90, 8'h48); wr(8'h91, 8'h81); wr(8'hA2, 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_valid", cu_valid, 0);
    chk("rst_data", {cu_instr, cu_opnd}, 0);
    chk("rst_flags", {busy, done, err}, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    tick();
    load3();
    chk("count3", count, 3);
    start();
    chk("busy_run", busy, 1);
    wait_done(3);
    // backpressure on entry 1 plus an illegal write while running
    start();
    tick();
    cu_ready = 1'b0; host_wr = 1'b1; host_instr = 8'hEE; host_opnd = 8'hEE;
    tick();
    host_wr = 1'b0;
    tick();
    cu_ready = 1'b1;
    wait_done(5);
    chk("err_run_wr", err, 1);
    chk("count_run_wr", count, 3);
    // overflow
    clr();
    chk("clr_err", err, 0);
    for (int i = 0; i < 9; i++) wr(8'h10 + 8'(i), 8'h20 + 8'(i));
    chk("full_count", count, 8);
    chk("full_err", err, 1);
    start();
    wait_done(8);
    clr();
    chk("clr_count", count, 0);
    chk("clr_err2", err, 0);
    start();
    wait_done(0);
    // abort after the first transfer; the same-cycle transfer is still taken
    load3();
    start();
    tick();
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    chk("abort_valid", cu_valid, 0);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_count", count, 3);
    start();
    wait_done(3);
    // enable freeze mid-run
    start();
    tick();
    ena = 1'b0;
    repeat (3) tick();
    chk("frz_valid", cu_valid, 1);
    chk("frz_data", {cu_instr, cu_opnd}, 16'h9181);
    ena = 1'b1;
    wait_done(6);
`ifdef SEQ_LOOP_EN
    host_loop = 1'b1;
    start();
    foreach (prog[i]) exp_q.push_back(prog[i]);
    foreach (prog[i]) exp_q.push_back(prog[i]);
    d0 = done_cnt;
    repeat (8) tick();
    chk("loop_busy", busy, 1);
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    host_loop = 1'b0;
    chk("loop_valid", cu_valid, 0);
    chk("loop_sb", exp_q.size(), 0);
    chk("loop_no_done", done_cnt, d0);
`else
    host_loop = 1'b1;
    start();
    wait_done(3);
    host_loop = 1'b0;
`endif
    // asynchronous reset mid-run
    start();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", cu_valid, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    prog.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_count", count, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
